// File: rtl/me_pkg.sv
// Shared definitions for the SAD motion-estimation engine: default geometry,
// FSM state encoding and a constant-foldable ceiling-log2 helper.
package me_pkg;

  localparam int BLK_DEF   = 16;
  localparam int RANGE_DEF = 8;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sad_accum.sv
// Absolute-difference accumulator: reloads on a candidate's first pixel and
// saturates at all ones so an overflowing SAD still compares as "worst".
module sad_accum #(
  parameter int DW   = 8,
  parameter int ACCW = 12
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            valid,
  input  logic            first,
  input  logic [DW-1:0]   r_pix,
  input  logic [DW-1:0]   s_pix,
  output logic [ACCW-1:0] acc,
  output logic [ACCW-1:0] acc_next
);

  logic signed [DW:0] diff;
  logic [DW-1:0]      mag;
  logic [ACCW:0]      sum;
  logic [ACCW-1:0]    acc_q, acc_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    diff  = $signed({1'b0, r_pix}) - $signed({1'b0, s_pix});
    mag   = diff[DW] ? DW'(-diff) : diff[DW-1:0];
    sum   = {1'b0, acc_q} + (ACCW+1)'(mag);
    acc_d = acc_q;
    if (valid) begin
      if (first)         acc_d = ACCW'(mag);
      else if (sum[ACCW]) acc_d = '1;
      else               acc_d = sum[ACCW-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign acc      = acc_q;
  assign acc_next = acc_d;

endmodule

// File: rtl/sad_search_engine.sv
// Full-search block matcher: walks every candidate offset, accumulates SAD
// through a 1-cycle-latency memory pipeline and reports the best vector.
module sad_search_engine
  import me_pkg::*;
#(
  parameter  int BLK   = BLK_DEF,
  parameter  int RANGE = RANGE_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int ACCW  = DW + 2*clog2(BLK),
  localparam int SW    = BLK + 2*RANGE,
  localparam int RAW   = clog2(BLK*BLK),
  localparam int SAW   = clog2(SW*SW),
  localparam int VW    = clog2(RANGE) + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            early_term_en,
  output logic            busy,
  output logic            done,
  output logic [RAW-1:0]  addr_r,
  input  logic [DW-1:0]   r_data,
  output logic [SAW-1:0]  addr_s,
  input  logic [DW-1:0]   s_data,
  output logic [ACCW-1:0] best_dist,
  output logic [VW-1:0]   motion_x,
  output logic [VW-1:0]   motion_y
);

  localparam int SP = 2*RANGE;
  localparam int PW = (clog2(BLK) > 0) ? clog2(BLK) : 1;
  localparam int CW = (clog2(SP) > 0) ? clog2(SP) : 1;

  state_e          state_q;
  logic [PW-1:0]   px_q, py_q;
  logic [CW-1:0]   cx_q, cy_q, cx_nxt, cy_nxt;
  logic            early_q;

  // Stage 1: read data returning; stage 2: candidate SAD complete in sad_q.
  logic            v1_q, first1_q, lastp1_q, lastc1_q;
  logic [CW-1:0]   cx1_q, cy1_q;
  logic            v2_q, lastc2_q;
  logic [CW-1:0]   cx2_q, cy2_q;

  logic            best_valid_q;
  logic [ACCW-1:0] best_q;
  logic [CW-1:0]   bx_q, by_q;
  logic            done_q;
  logic [ACCW-1:0] best_dist_q;
  logic [VW-1:0]   motion_x_q, motion_y_q;

  logic            issue, first0, lastp0, lastc0, abort, win;
  logic [ACCW-1:0] sad_q, sad_d, best_d;
  logic [CW-1:0]   bx_d, by_d;

  sad_accum #(.DW(DW), .ACCW(ACCW)) u_accum (
    .clock    (clock),
    .reset_n  (reset_n),
    .valid    (v1_q),
    .first    (first1_q),
    .r_pix    (r_data),
    .s_pix    (s_data),
    .acc      (sad_q),
    .acc_next (sad_d)
  );

  always_comb begin
    issue  = (state_q == S_RUN);
    first0 = (px_q == '0) && (py_q == '0);
    lastp0 = (px_q == PW'(BLK-1)) && (py_q == PW'(BLK-1));
    lastc0 = (cx_q == CW'(SP-1)) && (cy_q == CW'(SP-1));
    cx_nxt = (cx_q == CW'(SP-1)) ? '0 : cx_q + CW'(1);
    cy_nxt = (cx_q == CW'(SP-1)) ? cy_q + CW'(1) : cy_q;
    // The last candidate is never aborted; it simply runs into DRAIN.
    abort  = issue && early_q && v1_q && !lastp1_q && !lastc1_q &&
             best_valid_q && (sad_d >= best_q);
    win    = v2_q && (!best_valid_q || (sad_q < best_q));
    best_d = win ? sad_q : best_q;
    bx_d   = win ? cx2_q : bx_q;
    by_d   = win ? cy2_q : by_q;
  end

  always_comb begin
    addr_r = '0;
    addr_s = '0;
    if (issue) begin
      addr_r = RAW'(int'(py_q) * BLK + int'(px_q));
      addr_s = SAW'((int'(cy_q) + int'(py_q)) * SW + int'(cx_q) + int'(px_q));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      px_q         <= '0;
      py_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      early_q      <= 1'b0;
      v1_q         <= 1'b0;
      first1_q     <= 1'b0;
      lastp1_q     <= 1'b0;
      lastc1_q     <= 1'b0;
      cx1_q        <= '0;
      cy1_q        <= '0;
      v2_q         <= 1'b0;
      lastc2_q     <= 1'b0;
      cx2_q        <= '0;
      cy2_q        <= '0;
      best_valid_q <= 1'b0;
      best_q       <= '1;
      bx_q         <= '0;
      by_q         <= '0;
      done_q       <= 1'b0;
      best_dist_q  <= '1;
      motion_x_q   <= '0;
      motion_y_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      v1_q     <= issue && !abort;
      first1_q <= first0;
      lastp1_q <= lastp0;
      lastc1_q <= lastc0;
      cx1_q    <= cx_q;
      cy1_q    <= cy_q;
      v2_q     <= v1_q && lastp1_q;
      lastc2_q <= lastc1_q;
      cx2_q    <= cx1_q;
      cy2_q    <= cy1_q;

      if (v2_q) begin
        best_valid_q <= 1'b1;
        best_q       <= best_d;
        bx_q         <= bx_d;
        by_q         <= by_d;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_RUN;
            early_q      <= early_term_en;
            best_valid_q <= 1'b0;
            best_q       <= '1;
            px_q         <= '0;
            py_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
          end
        end
        S_RUN: begin
          if (abort || lastp0) begin
            px_q <= '0;
            py_q <= '0;
            if (!abort && lastc0) state_q <= S_DRAIN;
            else begin
              cx_q <= cx_nxt;
              cy_q <= cy_nxt;
            end
          end else if (px_q == PW'(BLK-1)) begin
            px_q <= '0;
            py_q <= py_q + PW'(1);
          end else begin
            px_q <= px_q + PW'(1);
          end
        end
        S_DRAIN: begin
          if (v2_q && lastc2_q) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b1;
            best_dist_q <= best_d;
            motion_x_q  <= VW'(int'(bx_d) - RANGE);
            motion_y_q  <= VW'(int'(by_d) - RANGE);
            cx_q        <= '0;
            cy_q        <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign best_dist = best_dist_q;
  assign motion_x  = motion_x_q;
  assign motion_y  = motion_y_q;

endmodule

// File: tb/tb_sad_search_engine.sv
// Bench for sad_search_engine: two instances (wide and 8-bit saturating SAD)
// share the same pixel memories and are compared against a loop-based model.
module tb_sad_search_engine;

  localparam int BLK   = 4;
  localparam int RANGE = 2;
  localparam int SP    = 2*RANGE;
  localparam int SW    = BLK + 2*RANGE;
  localparam int N     = SP*SP*BLK*BLK;
  localparam int WIN   = 300;

  logic        clock = 1'b0;
  logic        reset_n, start, early;
  logic [7:0]  rmem [BLK*BLK];
  logic [7:0]  smem [SW*SW];

  logic        busy_a, done_a, busy_b, done_b;
  logic [3:0]  addr_r_a, addr_r_b;
  logic [5:0]  addr_s_a, addr_s_b;
  logic [7:0]  r_data_a, s_data_a, r_data_b, s_data_b;
  logic [11:0] best_a;
  logic [7:0]  best_b;
  logic [1:0]  mx_a, my_a, mx_b, my_b;

  int checks = 0;
  int errors = 0;
  int done_cyc_a;

  always #5 clock = ~clock;

  sad_search_engine #(.BLK(BLK), .RANGE(RANGE), .DW(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .early_term_en(early),
    .busy(busy_a), .done(done_a), .addr_r(addr_r_a), .r_data(r_data_a),
    .addr_s(addr_s_a), .s_data(s_data_a), .best_dist(best_a),
    .motion_x(mx_a), .motion_y(my_a)
  );

  sad_search_engine #(.BLK(BLK), .RANGE(RANGE), .DW(8), .ACCW(8)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .early_term_en(early),
    .busy(busy_b), .done(done_b), .addr_r(addr_r_b), .r_data(r_data_b),
    .addr_s(addr_s_b), .s_data(s_data_b), .best_dist(best_b),
    .motion_x(mx_b), .motion_y(my_b)
  );

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clock) begin
    r_data_a <= rmem[addr_r_a];
    s_data_a <= smem[addr_s_a];
    r_data_b <= rmem[addr_r_b];
    s_data_b <= smem[addr_s_b];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Exhaustive search straight from the definition: saturated SAD, first wins ties.
  task automatic ref_search(input int accw, output int best, output int mx, output int my);
    int sat, sad, d;
    sat  = (1 << accw) - 1;
    best = 0; mx = 0; my = 0;
    for (int vy = -RANGE; vy < RANGE; vy++) begin
      for (int vx = -RANGE; vx < RANGE; vx++) begin
        sad = 0;
        for (int py = 0; py < BLK; py++) begin
          for (int px = 0; px < BLK; px++) begin
            d = int'(rmem[py*BLK+px]) - int'(smem[(vy+RANGE+py)*SW + vx+RANGE+px]);
            sad += (d < 0) ? -d : d;
          end
        end
        if (sad > sat) sad = sat;
        if ((vy == -RANGE && vx == -RANGE) || sad < best) begin
          best = sad; mx = vx; my = vy;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    int eb, ex, ey;
    ref_search(12, eb, ex, ey);
    check({tag, "_best"}, best_a, eb);
    check({tag, "_mx"}, int'($signed(mx_a)), ex);
    check({tag, "_my"}, int'($signed(my_a)), ey);
    ref_search(8, eb, ex, ey);
    check({tag, "_sat_best"}, best_b, eb);
    check({tag, "_sat_mx"}, int'($signed(mx_b)), ex);
    check({tag, "_sat_my"}, int'($signed(my_b)), ey);
  endtask

  task automatic copy_r_to_s(input int ox, input int oy);
    for (int py = 0; py < BLK; py++)
      for (int px = 0; px < BLK; px++)
        smem[(oy+RANGE+py)*SW + ox+RANGE+px] = rmem[py*BLK+px];
  endtask

  task automatic fill_scen1();
    for (int i = 0; i < BLK*BLK; i++) rmem[i] = 8'($urandom_range(0, 254));
    for (int i = 0; i < SW*SW; i++)   smem[i] = 8'd255;
    copy_r_to_s(1, -2);
  endtask

  task automatic fill_const(input logic [7:0] rv, input logic [7:0] sv);
    for (int i = 0; i < BLK*BLK; i++) rmem[i] = rv;
    for (int i = 0; i < SW*SW; i++)   smem[i] = sv;
  endtask

  // Start one search and watch a fixed window; done cycle counts edges after the sampling edge.
  task automatic run_search(input string tag, input logic early_en, input logic repulse);
    int cnt_a, cnt_b;
    cnt_a = 0; cnt_b = 0; done_cyc_a = -1;
    @(negedge clock);
    early = early_en;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      if (repulse && (c == 5 || c == 50)) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      if (c == 1) check({tag, "_busy"}, busy_a, 1);
      if (done_a) begin
        cnt_a++;
        if (done_cyc_a < 0) done_cyc_a = c;
      end
      if (done_b) cnt_b++;
    end
    check({tag, "_done_count"}, cnt_a, 1);
    check({tag, "_sat_done_count"}, cnt_b, 1);
    check({tag, "_idle_busy"}, busy_a, 0);
    check({tag, "_idle_addr"}, {addr_r_a, addr_s_a}, 0);
  endtask

  task automatic check_scen1(input string tag);
    check({tag, "_best"}, best_a, 0);
    check({tag, "_mx"}, int'($signed(mx_a)), 1);
    check({tag, "_my"}, int'($signed(my_a)), -2);
    check({tag, "_sat_best"}, best_b, 0);
    check({tag, "_sat_mx"}, int'($signed(mx_b)), 1);
    check({tag, "_sat_my"}, int'($signed(my_b)), -2);
  endtask

  initial begin
    int seen, ox, oy, maxv;
    logic e;
    reset_n = 1'b0; start = 1'b0; early = 1'b0;
    fill_const(8'd0, 8'd0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_best", best_a, 12'hFFF);
    check("rst_sat_best", best_b, 8'hFF);
    check("rst_motion", {mx_a, my_a}, 0);
    check("rst_addr", {addr_r_a, addr_s_a}, 0);
    @(negedge clock) reset_n = 1'b1;

    // Scenario 1: exact match at (+1,-2), early off.
    fill_scen1();
    run_search("s1", 1'b0, 1'b0);
    check("s1_done_cycle", done_cyc_a, N+2);
    check_scen1("s1");
    check_model("s1m");

    // Scenario 2: all zero, first candidate wins the tie.
    fill_const(8'd0, 8'd0);
    run_search("s2", 1'b0, 1'b0);
    check("s2_best", best_a, 0);
    check("s2_mx", int'($signed(mx_a)), -2);
    check("s2_my", int'($signed(my_a)), -2);

    // Scenario 3: saturating 8-bit SAD.
    fill_const(8'd255, 8'd0);
    run_search("s3", 1'b0, 1'b0);
    check("s3_sat_best", best_b, 255);
    check("s3_sat_mx", int'($signed(mx_b)), -2);
    check("s3_sat_my", int'($signed(my_b)), -2);
    check_model("s3m");

    // Scenario 4: scenario 1 data with early termination.
    fill_scen1();
    run_search("s4", 1'b1, 1'b0);
    check("s4_done_earlier", (done_cyc_a > 0 && done_cyc_a < N+2), 1);
    check_scen1("s4");

    // Scenario 5: reset in the middle of RUN.
    fill_scen1();
    @(negedge clock);
    early = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (100) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("s5_busy", busy_a, 0);
    check("s5_best", best_a, 12'hFFF);
    check("s5_sat_best", best_b, 8'hFF);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1 if (done_a || done_b) seen++;
    end
    @(negedge clock) reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1 if (done_a || done_b) seen++;
    end
    check("s5_no_done", seen, 0);
    run_search("s5r", 1'b0, 1'b0);
    check("s5r_done_cycle", done_cyc_a, N+2);
    check_scen1("s5r");

    // Scenario 6: start re-pulsed while busy is ignored.
    run_search("s6", 1'b0, 1'b1);
    check("s6_done_cycle", done_cyc_a, N+2);
    check_scen1("s6");

    // Randomized searches, small value ranges included to provoke ties.
    for (int t = 0; t < 6; t++) begin
      maxv = (t % 2 == 0) ? 3 : 255;
      for (int i = 0; i < BLK*BLK; i++) rmem[i] = 8'($urandom_range(0, maxv));
      for (int i = 0; i < SW*SW; i++)   smem[i] = 8'($urandom_range(0, maxv));
      ox = int'($urandom_range(0, SP-1)) - RANGE;
      oy = int'($urandom_range(0, SP-1)) - RANGE;
      if (t != 4) copy_r_to_s(ox, oy);
      if (t == 3) smem[(oy+RANGE)*SW + ox+RANGE] = ~rmem[0];
      e = 1'($urandom_range(0, 1));
      run_search($sformatf("rnd%0d", t), e, 1'b0);
      if (e) check($sformatf("rnd%0d_done_in_bound", t), (done_cyc_a > 0 && done_cyc_a <= N+2), 1);
      else   check($sformatf("rnd%0d_done_cycle", t), done_cyc_a, N+2);
      check_model($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sad_search_engine.md
SAD_SEARCH_ENGINE -- requirements
Module: sad_search_engine

Interface
REQ-001 Parameters SHALL be:
- BLK, default 16, reference block edge in pixels.
- RANGE, default 8, search offsets -RANGE..RANGE-1 per axis (SP = 2*RANGE).
- DW, default 8, pixel width.
- ACCW, default DW+2*clog2(BLK), SAD width.
REQ-002 Derived widths SHALL be:
- SW = BLK+2*RANGE (search window edge).
- RAW = clog2(BLK*BLK).
- SAW = clog2(SW*SW).
- VW = clog2(RANGE)+1.
REQ-003 Ports SHALL be (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- start  in  1  request a search, sampled in IDLE
- early_term_en  in  1  candidate early abort, latched at start
- busy  out  1  search in progress
- done  out  1  one-cycle completion pulse
- addr_r  out  RAW  reference address = py*BLK+px
- r_data  in  DW  reference pixel, 1-cycle read latency
- addr_s  out  SAW  search address = (vy+RANGE+py)*SW + (vx+RANGE+px)
- s_data  in  DW  search pixel, 1-cycle read latency
- best_dist  out  ACCW  minimum SAD of last completed search
- motion_x  out  VW  signed vx of best candidate
- motion_y  out  VW  signed vy of best candidate

Function
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN. Transitions:
- IDLE->RUN on start.
- RUN->DRAIN after the last address is issued.
- DRAIN->IDLE after the final compare.
REQ-005 start SHALL be ignored while busy=1; busy SHALL be 1 in RUN and DRAIN.
REQ-006 Candidate order SHALL be vy outer, vx inner, each running -RANGE..RANGE-1; pixel order within a candidate SHALL be py outer, px inner.
REQ-007 One address pair SHALL be issued per cycle in RUN; returned data SHALL be consumed exactly one cycle later.
REQ-008 Difference SHALL be computed in DW+1 bits; magnitude |r-s| SHALL be added to the accumulator.
REQ-009 Accumulation SHALL saturate at 2^ACCW-1.
REQ-010 Accumulator SHALL reload with the difference (not add) on each candidate's first pixel.
REQ-011 At each candidate's final pixel, the complete SAD SHALL be compared with the internal best:
- The first candidate of a search SHALL always load.
- Thereafter, strictly-less SHALL replace; ties keep the earlier candidate.
REQ-012 With early_term_en=1, once partial SAD >= internal best (after the first candidate), the address generator SHALL skip to the next candidate's first pixel on the following cycle. The in-flight read SHALL be discarded and the candidate SHALL NOT update best.
REQ-013 The skip at REQ-012 SHALL NOT occur if the aborted candidate is the last one; in that case the engine SHALL proceed to DRAIN.
REQ-014 With early_term_en=0, done SHALL pulse exactly N+2 cycles after the start-sampling edge, N = SP*SP*BLK*BLK.
REQ-015 best_dist, motion_x and motion_y SHALL update only in the done cycle and SHALL hold their value until the next done.
REQ-016 addr_r and addr_s SHALL hold 0 in IDLE.

Reset
REQ-017 reset_n low SHALL immediately force:
- state IDLE, busy 0, done 0
- best_dist all ones, motion_x 0, motion_y 0
- addresses 0, accumulator and counters 0
REQ-018 Reset mid-search SHALL abandon the search without any done pulse.

Structure
REQ-019 Package me_pkg SHALL hold the clog2 function, the FSM state enum, and default parameter constants.
REQ-020 Sub-module sad_accum SHALL implement abs-difference, saturating accumulate and first-pixel reload; the address generator, FSM and best-tracking stay in sad_search_engine.

Verification
All scenarios use BLK=4, RANGE=2 (N=256) unless noted.
REQ-021 Scenario 1: R copied into S at offset (+1,-2), all other S=255, early off -> done at cycle 258, best_dist=0, motion_x=1, motion_y=-2.
REQ-022 Scenario 2: R and S all zero -> best_dist=0, motion (-2,-2) (first candidate wins the tie).
REQ-023 Scenario 3: ACCW=8, R=255, S=0 -> best_dist=255 (saturated), motion (-2,-2).
REQ-024 Scenario 4: scenario 1 data with early_term_en=1 -> identical results, done earlier than cycle 258.
REQ-025 Scenario 5: reset_n low at cycle 100 of RUN -> busy=0 and best_dist=all ones next sample with no done pulse; a subsequent start reproduces scenario 1.
REQ-026 Scenario 6: start pulsed at cycles 5 and 50 of a run -> exactly one done, results unchanged from scenario 1.
